// File: rtl/am_err_monitor.sv
// am_err_monitor: error statistics for a stream of 8x8 approximate products.
// Each accepted sample recomputes the exact product and accumulates the signed
// error, absolute error, maximum absolute error and erroneous-sample count over
// a window of 2^N_LOG2 samples.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a window (honoured in IDLE or DONE only)
//   in_valid/in_ready  sample handshake; a transfer is in_valid && in_ready
//   x, y, z_approx     operands and approximate product
//   busy, done         busy in RUN/DRAIN, done level in DONE
//   sum_err            signed sum of (z_approx - x*y)
//   sum_abs_err        sum of |z_approx - x*y|
//   max_abs_err        largest |z_approx - x*y|
//   err_count          number of samples with z_approx != x*y
module am_err_monitor #(
  parameter int unsigned N_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          x,
  input  logic [7:0]          y,
  input  logic [15:0]         z_approx,
  output logic                busy,
  output logic                done,
  output logic [16+N_LOG2:0]  sum_err,
  output logic [15+N_LOG2:0]  sum_abs_err,
  output logic [15:0]         max_abs_err,
  output logic [N_LOG2:0]     err_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [N_LOG2:0] CntOne  = {{N_LOG2{1'b0}}, 1'b1};
  localparam logic [N_LOG2:0] LastCnt = {1'b0, {N_LOG2{1'b1}}};

  state_e            state_q;
  logic [N_LOG2:0]   cnt_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q;

  logic              s1_valid_q;
  logic [16:0]       e_q;
  logic [15:0]       a_q;
  logic              nz_q;

  logic [16+N_LOG2:0] sum_err_q;
  logic [15+N_LOG2:0] sum_abs_err_q;
  logic [15:0]        max_abs_err_q;
  logic [N_LOG2:0]    err_count_q;

  logic              xfer;
  logic              clear;
  logic [15:0]       prod;
  logic [16:0]       err;
  logic [16:0]       err_neg;
  logic [15:0]       abs_err;

  assign xfer  = in_valid & in_ready_q;
  assign clear = start & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    prod    = 16'(x) * 16'(y);
    err     = {1'b0, z_approx} - {1'b0, prod};
    err_neg = 17'd0 - err;
    // Magnitude fits 16 bits: positive max 65535, negative max 65025.
    abs_err = err[16] ? err_neg[15:0] : err[15:0];
  end

  // Control FSM; in_ready/busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        StRun: begin
          if (xfer) begin
            cnt_q <= cnt_q + CntOne;
            if (cnt_q == LastCnt) begin
              state_q    <= StDrain;
              in_ready_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Stage 1 empty means the last sample has been accumulated.
          if (!s1_valid_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Two-stage datapath: stage 1 captures error terms, stage 2 accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      e_q           <= '0;
      a_q           <= '0;
      nz_q          <= 1'b0;
      sum_err_q     <= '0;
      sum_abs_err_q <= '0;
      max_abs_err_q <= '0;
      err_count_q   <= '0;
    end else begin
      s1_valid_q <= xfer;
      if (xfer) begin
        e_q  <= err;
        a_q  <= abs_err;
        nz_q <= |err;
      end
      // clear only fires in IDLE/DONE where stage 1 is always empty.
      if (clear) begin
        sum_err_q     <= '0;
        sum_abs_err_q <= '0;
        max_abs_err_q <= '0;
        err_count_q   <= '0;
      end else if (s1_valid_q) begin
        sum_err_q     <= sum_err_q + {{N_LOG2{e_q[16]}}, e_q};
        sum_abs_err_q <= sum_abs_err_q + {{N_LOG2{1'b0}}, a_q};
        err_count_q   <= err_count_q + {{N_LOG2{1'b0}}, nz_q};
        if (a_q > max_abs_err_q) begin
          max_abs_err_q <= a_q;
        end
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sum_err     = sum_err_q;
  assign sum_abs_err = sum_abs_err_q;
  assign max_abs_err = max_abs_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_am_err_monitor.sv
// Testbench for am_err_monitor with a 4-sample window. Expected statistics
// come from an integer-arithmetic model over the samples the bench transfers.
module tb_am_err_monitor;

  localparam int unsigned NL   = 2;
  localparam int          WIN  = 1 << NL;
  localparam int          SE_W = 17 + NL;
  localparam int          SA_W = 16 + NL;
  localparam int          EC_W = NL + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        x = 8'd0;
  logic [7:0]        y = 8'd0;
  logic [15:0]       z_approx = 16'd0;
  logic              busy;
  logic              done;
  logic [SE_W-1:0]   sum_err;
  logic [SA_W-1:0]   sum_abs_err;
  logic [15:0]       max_abs_err;
  logic [EC_W-1:0]   err_count;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tx [WIN];
  logic [7:0]  ty [WIN];
  logic [15:0] tz [WIN];

  longint exp_se;
  longint exp_sa;
  longint exp_mx;
  longint exp_ec;

  am_err_monitor #(.N_LOG2(NL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .z_approx    (z_approx),
    .busy        (busy),
    .done        (done),
    .sum_err     (sum_err),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Reference: statistics of the first n table samples, plain integers.
  function automatic void model(input int n);
    longint e;
    longint ae;
    exp_se = 0; exp_sa = 0; exp_mx = 0; exp_ec = 0;
    for (int i = 0; i < n; i++) begin
      e  = longint'(tz[i]) - longint'(tx[i]) * longint'(ty[i]);
      ae = (e < 0) ? -e : e;
      exp_se += e;
      exp_sa += ae;
      if (ae > exp_mx) exp_mx = ae;
      if (e != 0) exp_ec++;
    end
  endfunction

  task automatic set_s(input int i, input int a, input int b, input int z);
    tx[i] = 8'(a);
    ty[i] = 8'(b);
    tz[i] = 16'(z);
  endtask

  task automatic fill_random();
    logic [15:0] p;
    for (int i = 0; i < WIN; i++) begin
      tx[i] = 8'($urandom);
      ty[i] = 8'($urandom);
      p = 16'(tx[i]) * 16'(ty[i]);
      case ($urandom_range(3))
        0: tz[i] = p;
        1: tz[i] = p + 16'($urandom_range(9));
        2: tz[i] = p - 16'($urandom_range(300));
        default: tz[i] = 16'($urandom);
      endcase
    end
  endtask

  // Pulse start, stream the table with the chosen valid pattern, and follow
  // the window through DRAIN into DONE. mode: 0 no bubbles, 1 fixed pattern,
  // 2 random bubbles. Begins and ends 1 time unit after a rising edge.
  task automatic drive_window(input int mode);
    int   acc;
    int   cyc;
    logic exp_ready;
    logic [6:0] pat;
    pat = 7'b1011001;
    acc = 0;
    cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0 || sum_err !== '0 ||
        sum_abs_err !== '0 || max_abs_err !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL start_clear busy=%b ready=%b done=%b se=%0h sa=%0h mx=%0h ec=%0h exp 1 1 0 0 0 0 0",
               busy, in_ready, done, sum_err, sum_abs_err, max_abs_err, err_count);
    end
    while (acc < WIN && cyc < 64) begin
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = pat[cyc % 7];
        default: in_valid = ($urandom_range(2) != 0);
      endcase
      x = tx[acc];
      y = ty[acc];
      z_approx = tz[acc];
      if (in_valid) acc++;
      @(posedge clk); #1;
      cyc++;
      exp_ready = (acc < WIN);
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
      end
    end
    if (acc < WIN) begin
      failures++;
      $display("FAIL window_timeout transfers got=%0d exp=%0d", acc, WIN);
    end
    // Extra sample after the window must be ignored.
    in_valid = 1'b1;
    x = 8'($urandom);
    y = 8'($urandom);
    z_approx = 16'($urandom);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL drain_state done=%b busy=%b exp done=0 busy=1", done, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_rise done=%b busy=%b ready=%b exp 1 0 0", done, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sum_err !== '0 ||
        sum_abs_err !== '0 || max_abs_err !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL reset_values ready=%b busy=%b done=%b se=%0h sa=%0h mx=%0h ec=%0h exp all 0",
               in_ready, busy, done, sum_err, sum_abs_err, max_abs_err, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold ready=%b busy=%b done=%b exp 0 0 0", in_ready, busy, done);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_latency();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    x = 8'd10; y = 8'd10; z_approx = 16'd105;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (sum_abs_err !== '0) begin
      failures++;
      $display("FAIL latency_early sum_abs_err got=%0d exp=0", sum_abs_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (sum_abs_err !== SA_W'(5) || sum_err !== SE_W'(5) || err_count !== EC_W'(1) ||
        max_abs_err !== 16'd5) begin
      failures++;
      $display("FAIL latency_t2 sa=%0d se=%0d ec=%0d mx=%0d exp 5 5 1 5",
               sum_abs_err, sum_err, err_count, max_abs_err);
    end
    in_valid = 1'b1;
    x = 8'd4; y = 8'd4; z_approx = 16'd16;
    repeat (WIN - 1) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || sum_abs_err !== SA_W'(5)) begin
      failures++;
      $display("FAIL latency_done done=%b sa=%0d exp done=1 sa=5", done, sum_abs_err);
    end
  endtask

  task automatic test_windows();
    int mode;
    for (int c = 0; c < 24; c++) begin
      case (c)
        0: begin
          set_s(0, 3, 5, 15);     set_s(1, 255, 255, 65025);
          set_s(2, 0, 7, 0);      set_s(3, 128, 2, 256);
        end
        1: begin
          set_s(0, 3, 5, 18);     set_s(1, 255, 255, 65028);
          set_s(2, 0, 7, 3);      set_s(3, 128, 2, 259);
        end
        2: begin
          set_s(0, 255, 255, 0);  set_s(1, 1, 1, 1);
          set_s(2, 2, 2, 6);      set_s(3, 0, 0, 65535);
        end
        default: fill_random();
      endcase
      if (c < 3) mode = 0;
      else if (c == 3) mode = 1;
      else mode = ($urandom_range(1) != 0) ? 2 : 0;
      drive_window(mode);
      model(WIN);
      checks++;
      if (sum_err !== SE_W'(exp_se)) begin
        failures++;
        $display("FAIL sum_err case=%0d got=%0d exp=%0d", c, $signed(sum_err), exp_se);
      end
      checks++;
      if (sum_abs_err !== SA_W'(exp_sa)) begin
        failures++;
        $display("FAIL sum_abs_err case=%0d got=%0d exp=%0d", c, sum_abs_err, exp_sa);
      end
      checks++;
      if (max_abs_err !== 16'(exp_mx)) begin
        failures++;
        $display("FAIL max_abs_err case=%0d got=%0d exp=%0d", c, max_abs_err, exp_mx);
      end
      checks++;
      if (err_count !== EC_W'(exp_ec)) begin
        failures++;
        $display("FAIL err_count case=%0d got=%0d exp=%0d", c, err_count, exp_ec);
      end
      // Outputs must hold while idling in DONE.
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || sum_abs_err !== SA_W'(exp_sa) || err_count !== EC_W'(exp_ec)) begin
        failures++;
        $display("FAIL done_hold case=%0d done=%b sa=%0d ec=%0d exp 1 %0d %0d",
                 c, done, sum_abs_err, err_count, exp_sa, exp_ec);
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    tz[0] = tz[0] + 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      in_valid = 1'b1;
      x = tx[i]; y = ty[i]; z_approx = tz[i];
      start = (i == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL start_in_run in_ready got=%b exp=0", in_ready);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_in_drain busy=%b done=%b exp 1 0", busy, done);
    end
    @(posedge clk); #1;
    model(WIN);
    checks++;
    if (done !== 1'b1 || sum_err !== SE_W'(exp_se) || sum_abs_err !== SA_W'(exp_sa) ||
        err_count !== EC_W'(exp_ec) || max_abs_err !== 16'(exp_mx)) begin
      failures++;
      $display("FAIL start_ignored_stats done=%b se=%0d sa=%0d ec=%0d mx=%0d exp 1 %0d %0d %0d %0d",
               done, $signed(sum_err), sum_abs_err, err_count, max_abs_err,
               exp_se, exp_sa, exp_ec, exp_mx);
    end
  endtask

  task automatic test_abort_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x = 8'd200; y = 8'd3; z_approx = 16'd7;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sum_err !== '0 ||
        sum_abs_err !== '0 || max_abs_err !== '0 || err_count !== '0) begin
      failures++;
      $display("FAIL abort_reset ready=%b busy=%b done=%b se=%0h sa=%0h mx=%0h ec=%0h exp all 0",
               in_ready, busy, done, sum_err, sum_abs_err, max_abs_err, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle ready=%b busy=%b done=%b exp 0 0 0", in_ready, busy, done);
      end
    end
    in_valid = 1'b0;
    fill_random();
    drive_window(0);
    model(WIN);
    checks++;
    if (sum_err !== SE_W'(exp_se) || sum_abs_err !== SA_W'(exp_sa) ||
        err_count !== EC_W'(exp_ec) || max_abs_err !== 16'(exp_mx)) begin
      failures++;
      $display("FAIL abort_next_window se=%0d sa=%0d ec=%0d mx=%0d exp %0d %0d %0d %0d",
               $signed(sum_err), sum_abs_err, err_count, max_abs_err,
               exp_se, exp_sa, exp_ec, exp_mx);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_windows();
    test_start_ignored();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
